// File: rtl/demux_1to4_buffer.sv
// demux_1to4_buffer: routes one 32-bit word per cycle into one of four per-destination FIFOs,
// each drained independently by its own valid/ready consumer.
module demux_1to4_buffer #(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     in_data,
    input  logic [1:0]      in_select,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     out_data_a,
    output logic [31:0]     out_data_b,
    output logic [31:0]     out_data_c,
    output logic [31:0]     out_data_d,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*CW-1:0] count,
    output logic            busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]  full;
    logic [31:0] head [4];

    assign in_ready   = !full[in_select];
    assign busy       = |out_valid;
    assign out_data_a = head[0];
    assign out_data_b = head[1];
    assign out_data_c = head[2];
    assign out_data_d = head[3];

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        logic [31:0]   mem_q [DEPTH];
        logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          push, pop;

        always_comb begin
            push  = in_valid && in_ready && (in_select == 2'(g));
            pop   = out_valid[g] && out_ready[g];
            wr_d  = push ? wr_q + PW'(1) : wr_q;
            rd_d  = pop ? rd_q + PW'(1) : rd_q;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        // storage is deliberately left uncleared by reset; only the pointers matter
        always_ff @(posedge clk) begin
            if (push && !rst) mem_q[wr_q] <= in_data;
        end

        assign full[g]             = cnt_q == CW'(DEPTH);
        assign out_valid[g]        = cnt_q != '0;
        assign count[g*CW +: CW]   = cnt_q;
        // gate with valid so never-written storage cannot leak X onto the port
        assign head[g]             = out_valid[g] ? mem_q[rd_q] : '0;
    end
endmodule

// File: tb/tb_demux_1to4_buffer.sv
// tb_demux_1to4_buffer: randomized producer/consumers with a queue-per-destination scoreboard.
module tb_demux_1to4_buffer;
    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic            clk = 0;
    logic            rst;
    logic [31:0]     in_data;
    logic [1:0]      in_select;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     out_data_a, out_data_b, out_data_c, out_data_d;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*CW-1:0] count;
    logic            busy;

    demux_1to4_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_select(in_select),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data_a(out_data_a), .out_data_b(out_data_b),
        .out_data_c(out_data_c), .out_data_d(out_data_d),
        .out_valid(out_valid), .out_ready(out_ready), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit active = 0;
    logic [31:0] exp_q [4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] odata(input int i);
        return i == 0 ? out_data_a : i == 1 ? out_data_b : i == 2 ? out_data_c : out_data_d;
    endfunction

    // monitor: compares every output against the model, then retires words the consumer takes
    always @(negedge clk) begin
        if (active) begin
            chk("in_ready", 32'(in_ready), 32'(exp_q[in_select].size() < DEPTH));
            chk("busy", 32'(busy), 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
                chk($sformatf("count%0d", i), 32'(count[i*CW +: CW]), 32'(exp_q[i].size()));
                chk($sformatf("known%0d", i), 32'($isunknown(odata(i))), 32'(0));
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("data%0d", i), odata(i), exp_q[i][0]);
                    if (out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    initial begin
        bit pend, held, was_rst;
        logic [1:0] psel;
        logic [31:0] pdata;
        rst = 1; in_valid = 0; in_select = 0; in_data = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        out_ready = 4'hf;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        for (int s = 0; s < 4; s++) begin
            in_select = 2'(s);
            #1 chk($sformatf("rst_ready%0d", s), 32'(in_ready), 32'(1));
        end
        active = 1;
        held = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 1200 || cyc == 2400);
            if (!held) begin
                in_valid  = $urandom_range(0, 3) != 0;
                in_select = 2'($urandom_range(0, 3));
                in_data   = $urandom;
            end
            // alternate stall-heavy and free-flowing consumer phases to reach full FIFOs
            out_ready = ((cyc / 100) % 3 == 0) ? ($urandom_range(0, 7) == 0 ? 4'($urandom) : 4'h0)
                                               : 4'($urandom);
            pend    = !rst && in_valid && exp_q[in_select].size() < DEPTH;
            held    = !rst && in_valid && !pend;
            psel    = in_select;
            pdata   = in_data;
            was_rst = rst;
            @(posedge clk);
            #1;
            if (was_rst) begin
                for (int i = 0; i < 4; i++) exp_q[i].delete();
                held = 0;
            end else if (pend) begin
                exp_q[psel].push_back(pdata);
            end
        end
        rst = 0; in_valid = 0; out_ready = 4'hf;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        chk("drained_valid", 32'(out_valid), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_1to4_buffer.md
# demux_1to4_buffer

Result distributor for the MIPS datapath: the inverse of the 4-to-1 selector. It takes one 32-bit word per cycle with a 2-bit destination select and routes it into one of four independent per-destination FIFOs, each drained by its own valid/ready consumer. It sits between a single producer, such as the write-back or result bus, and four consumers, decoupling them so that a stalled consumer blocks only words addressed to it.

## Interface
- DEPTH, 2, entries per destination FIFO; power of two, ≥2.
- CW, $clog2(DEPTH+1), width of each occupancy count (derived; not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  word to route.
- in_select  in  2  destination: 0→A, 1→B, 2→C, 3→D.
- in_valid  in  1  producer offers in_data/in_select this cycle.
- in_ready  out  1  selected destination can accept this cycle.
- out_data_a / out_data_b / out_data_c / out_data_d  out  32 each  head word of each FIFO.
- out_valid  out  4  bit i = FIFO i non-empty (bit 0 = A … bit 3 = D).
- out_ready  in  4  bit i = consumer i takes the head this cycle.
- count  out  4*CW  occupancy of FIFO i at bits [i*CW +: CW].
- busy  out  1  OR of out_valid.

## Operation
- Push: when in_valid & in_ready, in_data is written to the tail of FIFO[in_select] on the clock edge.
- in_ready = !full[in_select]. It is combinational from in_select and internal state only; there is no path from out_ready.
- Pop: when out_valid[i] & out_ready[i], the head of FIFO i is removed on the clock edge. All four FIFOs pop independently in the same cycle.
- Simultaneous push and pop on the same FIFO:
  - Legal whenever the FIFO is not full.
  - Count is unchanged.
  - The pushed word goes behind all existing entries.
- A full FIFO refuses a push even if its consumer pops in the same cycle. in_ready is low and the push is not taken; the producer must hold.
- Per-destination FIFO order is preserved. No ordering is defined across destinations.
- out_valid[i] & !out_ready[i]: out_data_x is held stable until the pop.
- in_valid low: in_select and in_data are don't-care, and no state changes from the input side.
- out_data_x is a don't-care when out_valid[i] is low; the implementation shall not drive X.
- Storage:
  - Each FIFO has an array of DEPTH×32, read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a CW-bit count.
  - full = (count == DEPTH), empty = (count == 0).
- Reset, synchronous and checked before any push or pop:
  - All counts and pointers are 0.
  - out_valid = 4'b0000, busy = 0, count = 0.
  - in_ready = 1 for every in_select.
  - Storage contents are not cleared.
- Reset mid-operation: all buffered words are discarded, and a push or pop presented in the reset cycle is ignored.

## Timing
- Latency: a word accepted at edge N is visible on out_valid and out_data in the cycle after edge N, and can be popped at edge N+1.
- Throughput: one push per cycle into one destination, plus up to four pops per cycle.
- in_ready for destination i rises in the cycle after a pop takes FIFO i from full to DEPTH-1. This gives one bubble per full→drain transition.
- out_data_x and out_valid are register outputs with no combinational input-to-output path. in_ready depends combinationally on in_select.
- count updates at the same edge as the push or pop it reflects.

## Test plan
- Reset, then push 0x0000_0011 with sel=2: at the next cycle out_valid=4'b0100, out_data_c=0x11, count C=1, busy=1. Pop with out_ready=4'b0100: out_valid=0 and busy=0 the next cycle.
- Fill A with DEPTH=2 (0xA0, 0xA1) while out_ready=0: in_ready=0 for sel=0 and 1 for sel=1. A third push 0xA2 to A is held, not lost. Pop once: in_ready rises the next cycle and 0xA2 is accepted. Drain order is 0xA0, 0xA1, 0xA2.
- Simultaneous push and pop on B at count 1 (head 0xB0, push 0xB1): count B stays 1 and the next head is 0xB1.
- Interleave pushes to D, A, D, C with all out_ready=1: each word appears exactly one cycle after acceptance on its own port, and order within D is preserved.
- Stall A full while pushing 0x5 to C: the C push is accepted and out_data_c=0x5, unaffected by A backpressure.
- Assert rst with all four FIFOs holding data and a push and pop active: the next cycle out_valid=0, all counts 0 and in_ready=1. The pushed word never appears.
